// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the f8 single-port data RAM.
// Port 0 is the core data bus; port 1 is the debug/program loader with a bounded bus lock.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned LOCK_MAX    = 4
) (
   input  logic                  clk,
   input  logic                  power_on_reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic                  lock1,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  grant,
   output logic                  busy
);

   localparam int unsigned WCNT_W = 3;
   localparam int unsigned LCNT_W = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t            state;
   logic [WCNT_W-1:0] wcnt;
   logic [LCNT_W-1:0] lock_cnt;
   logic              last_grant;
   logic              win_valid;
   logic              win_port;
   logic              win_by_lock;

   // Winner selection; only consumed while IDLE.
   always_comb begin
      win_valid   = req0 | req1;
      win_port    = 1'b0;
      win_by_lock = 1'b0;
      if (req0 && req1) begin
         if (last_grant && lock1 && (lock_cnt < LCNT_W'(LOCK_MAX))) begin
            win_port    = 1'b1;
            win_by_lock = 1'b1;
         end else begin
            win_port = ~last_grant;
         end
      end else begin
         win_port = req1;
      end
   end

   always_ff @(posedge clk) begin
      if (power_on_reset) begin
         state      <= IDLE;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         lock_cnt   <= '0;
         wcnt       <= '0;
         busy       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (!lock1) lock_cnt <= '0;
               if (win_valid) begin
                  state      <= ACCESS;
                  busy       <= 1'b1;
                  mem_en     <= 1'b1;
                  grant      <= win_port;
                  last_grant <= win_port;
                  mem_we     <= win_port ? we1    : we0;
                  mem_addr   <= win_port ? addr1  : addr0;
                  mem_wdata  <= win_port ? wdata1 : wdata0;
                  wcnt       <= WCNT_W'(WAIT_STATES);
                  // Lock count only advances while it is actually holding off port 0.
                  if (!win_port) begin
                     lock_cnt <= '0;
                  end else if (win_by_lock) begin
                     lock_cnt <= lock_cnt + LCNT_W'(1);
                  end
               end
            end
            ACCESS: begin
               if (wcnt != '0) begin
                  wcnt <= wcnt - WCNT_W'(1);
               end else begin
                  state  <= ACK;
                  mem_en <= 1'b0;
                  if (grant) begin
                     ack1 <= 1'b1;
                     if (!mem_we) rdata1 <= mem_rdata;
                  end else begin
                     ack0 <= 1'b1;
                     if (!mem_we) rdata0 <= mem_rdata;
                  end
               end
            end
            ACK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               mem_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the f8 system's single-port data RAM.
- Port 0 is the f8 core data bus. Port 1 is the debug/program loader, which fills or inspects memory while the core runs or is held.
- Round-robin arbitration with a bounded lock for port 1 multi-byte transfers.
- Fixed, parameterised wait states on the memory side.

Parameters:
- ADDR_WIDTH, 16, address width of both requesters and the RAM.
- DATA_WIDTH, 8, data width.
- WAIT_STATES, 1, extra cycles mem_en is held beyond the first; legal range 0..7.
- LOCK_MAX, 4, maximum consecutive locked grants to port 1 while port 0 is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- power_on_reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable; held stable with req0.
- addr0  in  ADDR_WIDTH  port 0 address; held stable with req0.
- wdata0  in  DATA_WIDTH  port 0 write data; held stable with req0.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_WIDTH  port 0 read data; valid only while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1.
- lock1  in  1  port 1 requests that it keep the bus on its next request.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable; qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; sampled on the last ACCESS cycle.
- grant  out  1  owner of the current or most recent access (0 or 1).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - state=IDLE
  - ack0=ack1=0, rdata0=rdata1=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - grant=0, last_grant=1 (so port 0 wins the first tie)
  - lock_cnt=0, busy=0
- IDLE:
  - Requests are sampled.
  - If neither req0 nor req1 is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high:
    - grant port 1 if last_grant=1, lock1=1 and lock_cnt<LOCK_MAX;
    - otherwise grant the port opposite last_grant.
  - On a grant, latch we/addr/wdata of the winner, set grant, load wcnt=WAIT_STATES, and go to ACCESS.
- ACCESS:
  - mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched registers.
  - If wcnt≠0: decrement wcnt and stay in ACCESS.
  - If wcnt=0: on a read, capture mem_rdata into the granted rdata register; go to ACK.
- ACK:
  - mem_en=0; ack of the granted port =1 for exactly this cycle.
  - No arbitration happens in ACK, so a request still high here is not re-granted.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T gives mem_en in cycles T+1..T+1+WAIT_STATES and ack at T+2+WAIT_STATES.
  - Back-to-back accesses from one port occupy WAIT_STATES+3 cycles each.
- last_grant and lock_cnt update on entry to ACCESS:
  - last_grant <= grant.
  - lock_cnt increments when port 1 was granted by the lock rule while req0 was high, saturating at LOCK_MAX.
  - lock_cnt clears on any port 0 grant or whenever lock1=0 in IDLE.
- rdata registers hold their last value outside ack; their content is don't-care outside ack.
- A write access leaves the rdata registers unchanged.
- A requester dropping req during ACCESS does not abort the access; ack is still issued.
- A requester changing addr/we/wdata during ACCESS has no effect, because the values were latched.
- Reset in any state, including mid-ACCESS: next cycle is IDLE with the reset values above.
  - The access is aborted and no ack is issued.
  - A write may have reached RAM.

Test Plan:
- WAIT_STATES=1, port 0 read at addr 0x0010 (RAM holds 0x5A) with req0 high at cycle 0 -> mem_en high cycles 1–2 with mem_addr=0x0010, mem_we=0; ack0 high at cycle 3 only, with rdata0=0x5A.
- req0 and req1 both raised at cycle 0 after reset, lock1=0 -> port 0 served first, then port 1; grant sequence 0,1,0,1 while both stay requesting; no ack ever goes to a non-requesting port.
- Port 1 with lock1=1, LOCK_MAX=4, both ports continuously requesting -> after the initial round-robin port 1 grant, port 1 is granted 4 more consecutive times, then port 0 is granted; lock_cnt returns to 0.
- Port 1 writes 0xA5 to 0x0200; port 0 then reads 0x0200 -> mem_we=1 with mem_wdata=0xA5 for WAIT_STATES+1 cycles; subsequent ack0 carries rdata0=0xA5.
- power_on_reset asserted in the second ACCESS cycle of a port 0 read -> next cycle mem_en=0, busy=0, no ack0 ever issued; after release, a pending req0 is re-arbitrated and completes normally.
- WAIT_STATES=0, single requester holding req0 continuously -> ack0 every 3 cycles; mem_en high exactly 1 cycle per access; req0 still high in the ACK cycle causes no extra grant.
